// File: rtl/axi_stream_mon_pkg.sv
// axi_stream_mon_pkg: shared error indices, packet FSM states and saturating add for the link monitor
package axi_stream_mon_pkg;
  localparam int ERR_VALID_DROP     = 0;
  localparam int ERR_PAYLOAD_CHANGE = 1;
  localparam int ERR_STRB_NO_KEEP   = 2;
  localparam int ERR_PKT_TOO_LONG   = 3;
  localparam int ERR_STALL_TIMEOUT  = 4;
  localparam int ERR_ID_CHANGE      = 5;
  localparam int ERR_W              = 6;
  typedef enum logic {IDLE, IN_PKT} state_t;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input logic [63:0] max);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[63:0];
  endfunction
endpackage

// File: rtl/axi_stream_popcount.sv
// axi_stream_popcount: number of set bits in a byte-lane mask
module axi_stream_popcount #(
  parameter int BYTE_WIDTH = 4,
  parameter int PW = $clog2(BYTE_WIDTH + 1)
) (
  input  logic [BYTE_WIDTH-1:0] bits,
  output logic [PW-1:0]         count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < BYTE_WIDTH; i++) count = count + PW'(bits[i]);
  end
endmodule

// File: rtl/axi_stream_link_monitor.sv
// axi_stream_link_monitor: passive AXI4-Stream monitor with statistics and sticky protocol-violation flags
module axi_stream_link_monitor
  import axi_stream_mon_pkg::*;
#(
  parameter int BYTE_WIDTH       = 4,
  parameter int ID_WIDTH         = 4,
  parameter int CNT_WIDTH        = 32,
  parameter int MAX_PKT_BEATS    = 256,
  parameter int STALL_TIMEOUT    = 1024,
  parameter int ALLOW_INTERLEAVE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    tvalid,
  input  logic                    tready,
  input  logic [8*BYTE_WIDTH-1:0] tdata,
  input  logic [BYTE_WIDTH-1:0]   tstrb,
  input  logic [BYTE_WIDTH-1:0]   tkeep,
  input  logic                    tlast,
  input  logic [ID_WIDTH-1:0]     tid,
  output logic [CNT_WIDTH-1:0]    beat_count,
  output logic [CNT_WIDTH-1:0]    packet_count,
  output logic [CNT_WIDTH-1:0]    byte_count,
  output logic                    in_packet,
  output logic [ERR_W-1:0]        err_flags,
  output logic                    err_pulse
);
  localparam int PW = $clog2(BYTE_WIDTH + 1);
  localparam int BW = $clog2(MAX_PKT_BEATS + 2);
  localparam int SW = $clog2(STALL_TIMEOUT + 2);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  state_t state, state_n;
  logic hv, pv, pr, pl;
  logic [BYTE_WIDTH-1:0] pk, ps;
  logic [ID_WIDTH-1:0] pid, pkt_id;
  logic [8*BYTE_WIDTH-1:0] pd;
  logic [BW-1:0] cur_beats;
  logic [SW-1:0] stall_cnt;
  logic long_seen, hs, stall, prev_stall, data_diff;
  logic [ERR_W-1:0] det;
  logic [PW-1:0] pop;
  logic [CNT_WIDTH-1:0] bc, pc, yc;
  axi_stream_popcount #(.BYTE_WIDTH(BYTE_WIDTH)) u_pop (.bits(tkeep & tstrb), .count(pop));
  always_comb begin
    hs = tvalid && tready;
    stall = tvalid && !tready;
    prev_stall = hv && pv && !pr;
    state_n = hs ? (tlast ? IDLE : IN_PKT) : state;
    data_diff = 1'b0;
    for (int i = 0; i < BYTE_WIDTH; i++)
      data_diff = data_diff | (tkeep[i] & tstrb[i] & (tdata[8*i+:8] != pd[8*i+:8]));
    det = '0;
    det[ERR_VALID_DROP] = prev_stall && !tvalid;
    det[ERR_PAYLOAD_CHANGE] = prev_stall && tvalid && (({tkeep, tstrb, tlast, tid} != {pk, ps, pl, pid}) || data_diff);
    det[ERR_STRB_NO_KEEP] = tvalid && |(tstrb & ~tkeep);
    det[ERR_PKT_TOO_LONG] = (MAX_PKT_BEATS != 0) && hs && state == IN_PKT && !long_seen && cur_beats >= BW'(MAX_PKT_BEATS);
    det[ERR_STALL_TIMEOUT] = (STALL_TIMEOUT != 0) && hv && stall && stall_cnt == SW'(STALL_TIMEOUT - 1);
    det[ERR_ID_CHANGE] = (ALLOW_INTERLEAVE == 0) && state == IN_PKT && hs && tid != pkt_id;
    bc = clear ? '0 : beat_count;
    pc = clear ? '0 : packet_count;
    yc = clear ? '0 : byte_count;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      {hv, pv, pr, pl, pk, ps, pid, pd} <= '0;
      {pkt_id, cur_beats, stall_cnt, long_seen} <= '0;
      {beat_count, packet_count, byte_count} <= '0;
      err_flags <= '0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_n;
      hv <= 1'b1;
      {pv, pr, pl, pk, ps, pid, pd} <= {tvalid, tready, tlast, tkeep, tstrb, tid, tdata};
      stall_cnt <= stall ? ((stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1) : '0;
      if (hs && state == IDLE) pkt_id <= tid;
      if (hs) cur_beats <= tlast ? '0 : (state == IDLE) ? BW'(1) : (cur_beats == '1) ? cur_beats : cur_beats + 1'b1;
      long_seen <= (hs && tlast) ? 1'b0 : long_seen | det[ERR_PKT_TOO_LONG];
      beat_count <= CNT_WIDTH'(sat_add(64'(bc), 64'(hs), 64'(CMAX)));
      packet_count <= CNT_WIDTH'(sat_add(64'(pc), 64'(hs && tlast), 64'(CMAX)));
      byte_count <= CNT_WIDTH'(sat_add(64'(yc), 64'(hs ? pop : '0), 64'(CMAX)));
      err_flags <= (clear ? '0 : err_flags) | det;
      err_pulse <= |(det & (clear ? {ERR_W{1'b1}} : ~err_flags));
    end
  end
  assign in_packet = (state == IN_PKT);
endmodule

// File: tb/tb_axi_stream_link_monitor.sv
// tb_axi_stream_link_monitor: directed checks of counters, FSM and violation flags on two monitor configurations
module tb_axi_stream_link_monitor;
  logic clk = 1'b0, reset, clear, tvalid, tready, tlast;
  logic [31:0] tdata;
  logic [3:0] tstrb, tkeep, tid;
  logic [31:0] beat0, pkt0, byte0;
  logic [2:0] beat1, pkt1, byte1;
  logic inp0, inp1, pul0, pul1;
  logic [5:0] flg0, flg1;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  axi_stream_link_monitor #(.STALL_TIMEOUT(4)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .beat_count(beat0), .packet_count(pkt0),
    .byte_count(byte0), .in_packet(inp0), .err_flags(flg0), .err_pulse(pul0));

  axi_stream_link_monitor #(.CNT_WIDTH(3), .MAX_PKT_BEATS(2), .STALL_TIMEOUT(4), .ALLOW_INTERLEAVE(1)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .beat_count(beat1), .packet_count(pkt1),
    .byte_count(byte1), .in_packet(inp1), .err_flags(flg1), .err_pulse(pul1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic r, input logic [3:0] k, input logic [3:0] s,
                     input logic l, input logic [3:0] i, input logic [31:0] d);
    tvalid = v; tready = r; tkeep = k; tstrb = s; tlast = l; tid = i; tdata = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear;
    drv(0, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    drv(0, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0);
    tick(); tick();
    chk("rst_beat", beat0, 0); chk("rst_pkt", pkt0, 0); chk("rst_byte", byte0, 0);
    chk("rst_inp", inp0, 0); chk("rst_flags", flg0, 0); chk("rst_pulse", pul0, 0);
    reset = 1'b0;
    tick();
    // 3-beat packet, strobes F/3/1
    drv(1, 1, 4'hF, 4'hF, 0, 4'h0, 32'h11223344); tick();
    chk("p3_inp_b1", inp0, 1); chk("p3_beat_b1", beat0, 1);
    drv(1, 1, 4'hF, 4'h3, 0, 4'h0, 32'h55667788); tick();
    chk("p3_inp_b2", inp0, 1);
    drv(1, 1, 4'hF, 4'h1, 1, 4'h0, 32'h99AABBCC); tick();
    chk("p3_beat", beat0, 3); chk("p3_pkt", pkt0, 1); chk("p3_byte", byte0, 7);
    chk("p3_inp_end", inp0, 0); chk("p3_flags", flg0, 0);
    chk("long_flag", flg1, 6'h08); chk("long_pulse", pul1, 1); chk("sat_byte_p3", byte1, 7);
    drv(0, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0); tick();
    chk("long_pulse_off", pul1, 0); chk("long_sticky", flg1, 6'h08);
    do_clear();
    chk("clr_beat", beat0, 0); chk("clr_flags1", flg1, 0);
    // tvalid dropped during a stall
    drv(1, 0, 4'hF, 4'hF, 0, 4'h0, 32'h0); tick(); tick();
    drv(0, 0, 4'hF, 4'hF, 0, 4'h0, 32'h0); tick();
    chk("vdrop_flags", flg0, 6'h01); chk("vdrop_pulse", pul0, 1);
    tick();
    chk("vdrop_pulse_off", pul0, 0); chk("vdrop_sticky", flg0, 6'h01); chk("vdrop_beat", beat0, 0);
    do_clear();
    // tkeep changed during a stall
    drv(1, 0, 4'hF, 4'hF, 0, 4'h0, 32'h0); tick();
    drv(1, 0, 4'h7, 4'h7, 0, 4'h0, 32'h0); tick();
    chk("keep_chg_flags", flg0, 6'h02); chk("keep_chg_pulse", pul0, 1);
    drv(1, 1, 4'h7, 4'h7, 1, 4'h0, 32'h0); tick();
    chk("keep_chg_sticky", flg0, 6'h02);
    do_clear();
    // data change on a masked byte is legal, on an enabled byte it is not
    drv(1, 0, 4'hF, 4'h1, 0, 4'h0, 32'h00000000); tick();
    drv(1, 0, 4'hF, 4'h1, 0, 4'h0, 32'h00AA0000); tick();
    chk("data_masked", flg0, 0);
    drv(1, 0, 4'hF, 4'h1, 0, 4'h0, 32'h00AA0055); tick();
    chk("data_live", flg0, 6'h02);
    drv(1, 1, 4'hF, 4'h1, 1, 4'h0, 32'h00AA0055); tick();
    do_clear();
    // strobe without keep
    drv(1, 1, 4'h1, 4'h3, 1, 4'h0, 32'h0); tick();
    chk("strb_nokeep", flg0, 6'h04);
    do_clear();
    // stall timeout after four stalled cycles
    drv(1, 0, 4'hF, 4'hF, 1, 4'h0, 32'h0); tick(); tick(); tick();
    chk("stall_3", flg0, 0);
    tick();
    chk("stall_4", flg0, 6'h10); chk("stall_pulse", pul0, 1);
    drv(1, 1, 4'hF, 4'hF, 1, 4'h0, 32'h0); tick();
    chk("stall_sticky", flg0, 6'h10);
    do_clear();
    // TID change mid-packet
    drv(1, 1, 4'hF, 4'hF, 0, 4'h1, 32'h0); tick();
    chk("id_inp", inp0, 1);
    drv(1, 1, 4'hF, 4'hF, 0, 4'h2, 32'h0); tick();
    chk("id_chg", flg0, 6'h20); chk("id_interleave_ok", flg1, 0);
    drv(1, 1, 4'hF, 4'hF, 1, 4'h2, 32'h0); tick();
    chk("id_inp_end", inp0, 0); chk("id_long_u1", flg1, 6'h08);
    do_clear();
    // saturation of 3-bit counters
    drv(1, 1, 4'hF, 4'hF, 1, 4'h0, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    chk("sat_beat", beat1, 7); chk("sat_pkt", pkt1, 7); chk("sat_byte", byte1, 7);
    chk("wide_beat", beat0, 9); chk("wide_pkt", pkt0, 9); chk("wide_byte", byte0, 36);
    // clear coincident with a handshake and a violation
    drv(1, 1, 4'h1, 4'h3, 1, 4'h0, 32'h0); clear = 1'b1; tick();
    chk("clr_hs_beat", beat0, 1); chk("clr_hs_byte", byte0, 1); chk("clr_hs_beat1", beat1, 1);
    chk("clr_viol_flag", flg0, 6'h04); chk("clr_viol_pulse", pul0, 1);
    tick();
    chk("clr_rerise_pulse", pul0, 1); chk("clr_rerise_flag", flg0, 6'h04); chk("clr_rerise_beat", beat0, 1);
    clear = 1'b0; tick();
    chk("norise_pulse", pul0, 0); chk("norise_beat", beat0, 2);
    do_clear();
    // reset mid-packet while stalled, then drop tvalid
    drv(1, 1, 4'hF, 4'hF, 0, 4'h0, 32'h0); tick();
    chk("mid_inp", inp0, 1);
    drv(1, 0, 4'hF, 4'hF, 0, 4'h0, 32'h0); tick();
    reset = 1'b1; tick();
    chk("mid_rst_beat", beat0, 0); chk("mid_rst_pkt", pkt0, 0); chk("mid_rst_byte", byte0, 0);
    chk("mid_rst_inp", inp0, 0); chk("mid_rst_flags", flg0, 0);
    reset = 1'b0;
    drv(0, 0, 4'h0, 4'h0, 0, 4'h0, 32'h0); tick();
    chk("post_rst_flags", flg0, 0); chk("post_rst_pulse", pul0, 0); chk("post_rst_inp", inp0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
